ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 98 +++++++++
 tb/tb_ex_mem_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with valid/ready handshake and flush.
//               Define EX_MEM_SKID_EN for a 2-entry skid buffer, otherwise a
//               single-entry register with a combinational ready path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [REG_W-1:0]  wb_reg_i,
   input  logic [4:0]        ctrl_i,
   input  logic              out_ready_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_result_o,
   output logic              out_zero_o,
   output logic [DATA_W-1:0] out_rt_data_o,
   output logic [REG_W-1:0]  out_wb_reg_o,
   output logic [4:0]        out_ctrl_o,
   output logic [1:0]        count_o
);

   localparam int ENT_W = 2*DATA_W + 1 + REG_W + 5;

   logic [ENT_W-1:0] w_in_ent;
   logic [ENT_W-1:0] w_head;
   logic [ENT_W-1:0] r_ent0;
`ifdef EX_MEM_SKID_EN
   logic [ENT_W-1:0] r_ent1;
`endif
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign w_in_ent    = {alu_result_i, alu_zero_i, rt_data_i, wb_reg_i, ctrl_i};
   assign out_valid_o = (r_count != 2'd0);

`ifdef EX_MEM_SKID_EN
   assign in_ready_o = (r_count != 2'd2);
`else
   assign in_ready_o = ~out_valid_o | out_ready_i;
`endif

   assign w_push = in_valid_i & in_ready_o & ~flush_i;
   assign w_pop  = out_valid_o & out_ready_i & ~flush_i;

   // Slot 0 is always the head; slot 1 only ever holds the younger entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= 2'd0;
         r_ent0  <= '0;
`ifdef EX_MEM_SKID_EN
         r_ent1  <= '0;
`endif
      end else if (flush_i) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_count <= r_count + 2'd1;
`ifdef EX_MEM_SKID_EN
               if (r_count == 2'd0) r_ent0 <= w_in_ent;
               else                 r_ent1 <= w_in_ent;
`else
               r_ent0 <= w_in_ent;
`endif
            end
            2'b01: begin
               r_count <= r_count - 2'd1;
`ifdef EX_MEM_SKID_EN
               r_ent0  <= r_ent1;
`endif
            end
            2'b11: r_ent0 <= w_in_ent;
            default: ;
         endcase
      end
   end

   // Bubbles present all-zero fields so downstream sees no write enables.
   assign w_head = out_valid_o ? r_ent0 : '0;
   assign {out_result_o, out_zero_o, out_rt_data_o, out_wb_reg_o, out_ctrl_o} = w_head;
   assign count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios then random traffic checked
// against a queue-based model of the buffer.
`default_nettype none

module tb_ex_mem_stage;

   localparam int DW = 32;
   localparam int RW = 5;
`ifdef EX_MEM_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] res;
      logic          z;
      logic [DW-1:0] rt;
      logic [RW-1:0] wb;
      logic [4:0]    ctrl;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, alu_zero, out_ready, out_valid, out_zero;
   logic [DW-1:0] alu_result, rt_data, out_result, out_rt_data;
   logic [RW-1:0] wb_reg, out_wb_reg;
   logic [4:0]    ctrl, out_ctrl;
   logic [1:0]    count;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];

   ex_mem_stage #(.DATA_W(DW), .REG_W(RW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero), .rt_data_i(rt_data),
      .wb_reg_i(wb_reg), .ctrl_i(ctrl), .out_ready_i(out_ready),
      .out_valid_o(out_valid), .out_result_o(out_result), .out_zero_o(out_zero),
      .out_rt_data_o(out_rt_data), .out_wb_reg_o(out_wb_reg), .out_ctrl_o(out_ctrl),
      .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] res, input logic [4:0] wb, input logic [4:0] c);
      ent_t e;
      e      = '0;
      e.res  = res;
      e.wb   = wb;
      e.ctrl = c;
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.res  = $urandom;
      e.z    = 1'($urandom_range(0, 1));
      e.rt   = $urandom;
      e.wb   = 5'($urandom_range(0, 31));
      e.ctrl = 5'($urandom_range(0, 31));
      return e;
   endfunction

   // One clock: drive, compare against the model, then advance the model.
   task automatic step(input bit r, input bit f, input bit v, input ent_t e,
                       input bit rdy, input bit do_chk);
      ent_t h;
      bit   exp_vld, exp_rdy, psh, pp;
      @(negedge clk);
      rst = r; flush = f; in_valid = v; out_ready = rdy;
      alu_result = e.res; alu_zero = e.z; rt_data = e.rt; wb_reg = e.wb; ctrl = e.ctrl;
      #1;
      exp_vld = (q.size() > 0);
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || rdy);
      h       = exp_vld ? q[0] : '0;
      if (do_chk) begin
         chk("out_valid", 32'(out_valid), 32'(exp_vld));
         chk("in_ready",  32'(in_ready),  32'(exp_rdy));
         chk("count",     32'(count),     32'(q.size()));
         chk("result",    out_result,     h.res);
         chk("zero",      32'(out_zero),  32'(h.z));
         chk("rt_data",   out_rt_data,    h.rt);
         chk("wb_reg",    32'(out_wb_reg), 32'(h.wb));
         chk("ctrl",      32'(out_ctrl),  32'(h.ctrl));
      end
      psh = v && exp_rdy && !f;
      pp  = exp_vld && rdy && !f;
      @(posedge clk);
      if (r || f) q.delete();
      else begin
         if (pp)  void'(q.pop_front());
         if (psh) q.push_back(e);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_result = '0; alu_zero = 1'b0; rt_data = '0; wb_reg = '0; ctrl = '0;
      step(1, 0, 0, '0, 1, 0);
      step(1, 0, 0, '0, 1, 1);

      // Single push with ready high, then explicit head values.
      step(0, 0, 1, mk(32'h5, 5'd3, 5'b00011), 1, 1);
      #1;
      chk("req033_valid",  32'(out_valid), 32'h1);
      chk("req033_result", out_result,     32'h5);
      chk("req033_wb",     32'(out_wb_reg), 32'h3);
      chk("req033_ctrl",   32'(out_ctrl),  32'h3);
      chk("req033_count",  32'(count),     32'h1);
      step(0, 0, 0, '0, 1, 1);

      // Fill with consumer stalled, third push refused, then drain in order.
      step(0, 0, 1, mk(32'h11, 5'd1, 5'b01010), 0, 1);
      step(0, 0, 1, mk(32'h22, 5'd2, 5'b00110), 0, 1);
      step(0, 0, 1, mk(32'h99, 5'd9, 5'b11111), 0, 1);
      step(0, 0, 0, '0, 1, 1);
      step(0, 0, 0, '0, 1, 1);
      step(0, 0, 0, '0, 1, 1);

      // Simultaneous push and pop at count 1 replaces the head.
      step(0, 0, 1, mk(32'h11, 5'd1, 5'b00011), 0, 1);
      step(0, 0, 1, mk(32'h33, 5'd4, 5'b00101), 1, 1);
      step(0, 0, 0, '0, 0, 1);
      step(0, 0, 0, '0, 1, 1);

      // Flush with a full buffer and a same-cycle input.
      step(0, 0, 1, mk(32'h44, 5'd5, 5'b00011), 0, 1);
      step(0, 0, 1, mk(32'h55, 5'd6, 5'b00011), 0, 1);
      step(0, 1, 1, mk(32'h66, 5'd7, 5'b00011), 0, 1);
      step(0, 0, 0, '0, 0, 1);

      // Reset mid-stream discards held entries.
      step(0, 0, 1, mk(32'h77, 5'd8, 5'b00011), 0, 1);
      step(0, 0, 1, mk(32'h88, 5'd9, 5'b00011), 0, 1);
      step(1, 0, 1, mk(32'hAA, 5'd10, 5'b00011), 1, 1);
      step(0, 0, 0, '0, 1, 1);
      step(0, 0, 1, mk(32'hBB, 5'd11, 5'b00001), 1, 1);
      step(0, 0, 1, mk(32'hCC, 5'd12, 5'b00010), 1, 1);
      step(0, 0, 0, '0, 1, 1);

      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0, rnd_ent(),
              (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
